// File: rtl/ssd_scan_scheduler.sv
// Multiplexed common-anode seven-segment scanner with per-slot dead-time blanking
// and a frame-boundary load/ack handshake for tear-free value updates.
module ssd_scan_scheduler #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 262144,
  parameter int unsigned BLANK_CYCLES = 1024
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [7:0]              cathode_n,
  output logic [2:0]              digit_idx
);

  localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state, state_nxt;
  logic [SW-1:0]           s, s_nxt;
  logic [2:0]              idx_nxt;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    last_slot, frame_end, latch;
  logic [3:0]              nib;
  logic                    dp_bit, en_bit;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  // Outputs are registered from next-cycle values so they line up with s and digit_idx.
  always_comb begin
    last_slot     = (s == SW'(SCAN_DIV - 1));
    frame_end     = last_slot && (digit_idx == 3'(NUM_DIGITS - 1));
    latch         = frame_end && load;
    s_nxt         = last_slot ? '0 : s + 1'b1;
    idx_nxt       = digit_idx;
    if (last_slot) idx_nxt = frame_end ? '0 : digit_idx + 3'd1;
    shadow_nxt    = latch ? value_in : shadow;
    shadow_dp_nxt = latch ? dp_in : shadow_dp;
    state_nxt     = ((BLANK_CYCLES != 0) && (32'(s_nxt) < BLANK_CYCLES)) ? BLANK : SHOW;
    nib    = '0;
    dp_bit = 1'b0;
    en_bit = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (3'(i) == idx_nxt) begin
        nib    = shadow_nxt[4*i +: 4];
        dp_bit = shadow_dp_nxt[i];
        en_bit = digit_en[i];
      end
    end
    an_nxt = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((state_nxt == SHOW) && (3'(i) == idx_nxt) && en_bit) an_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      state     <= BLANK;
      s         <= '0;
      digit_idx <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      load_ack  <= 1'b0;
      anode_n   <= '1;
      cathode_n <= 8'hFF;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      digit_idx <= idx_nxt;
      shadow    <= shadow_nxt;
      shadow_dp <= shadow_dp_nxt;
      load_ack  <= latch;
      anode_n   <= an_nxt;
      cathode_n <= (state_nxt == SHOW) ? {seg7(nib), ~dp_bit} : 8'hFF;
    end
  end

endmodule
